// File: rtl/branch_resolve_predict_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_resolve_predict_if                                       |
// | Purpose  : Bundles the fetch-prediction, EX-resolve and statistics signals |
// |            of the branch unit.                                             |
// | Ports    : slave  - the branch unit (EX/IF inputs in, results out)         |
// |            master - the pipeline side (drives EX/IF, observes results)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface branch_resolve_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // Fetch-side prediction
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;

  // EX-stage branch resolution
  logic             ex_valid;
  logic             ex_is_branch;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic             ex_pred_taken;
  logic             branch_taken;
  logic             mispredict;
  logic             illegal_funct3;

  // Performance counters
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_rs1, ex_rs2,
           ex_pred_taken,
    output pred_taken, branch_taken, mispredict, illegal_funct3,
           branch_count, mispredict_count
  );

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_rs1, ex_rs2,
           ex_pred_taken,
    input  pred_taken, branch_taken, mispredict, illegal_funct3,
           branch_count, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_predict.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_resolve_predict                                          |
// | Purpose  : Resolves RV32 conditional branches from EX operands, checks     |
// |            them against the carried prediction, trains a PC-indexed table  |
// |            of 2-bit saturating counters that predicts for IF, and counts   |
// |            resolved branches and mispredicts (saturating).                 |
// | Ports    : clk   - clock                                                   |
// |            rst_n - synchronous active-low reset                            |
// |            bus   - branch_resolve_predict_if.slave (prediction, resolve,   |
// |                    outcome and counter signals)                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module branch_resolve_predict #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  branch_resolve_predict_if.slave     bus
);

  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [1:0] C_BHT_RST = 2'b01;  // weakly not-taken

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // ---------------------------------------------------------------------------
  // Combinational resolve
  // ---------------------------------------------------------------------------
  logic             resolve;
  logic             cond_true;
  logic             funct3_bad;
  logic             legal_resolve;
  logic             taken;
  logic             mispred;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];

  always_comb begin
    cond_true  = 1'b0;
    funct3_bad = 1'b0;
    case (bus.ex_funct3)
      3'b000:  cond_true = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond_true = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond_true = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond_true = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond_true = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond_true = (bus.ex_rs1 >= bus.ex_rs2);
      default: funct3_bad = 1'b1;  // 010 / 011 are not branch encodings
    endcase

    resolve       = bus.ex_valid & bus.ex_is_branch;
    legal_resolve = resolve & ~funct3_bad;
    taken         = legal_resolve & cond_true;
    mispred       = legal_resolve & (taken != bus.ex_pred_taken);
  end

  assign bus.branch_taken     = taken;
  assign bus.mispredict       = mispred;
  assign bus.illegal_funct3   = resolve & funct3_bad;
  // Raw table read: an update in the same cycle becomes visible next cycle.
  assign bus.pred_taken       = bht_q[if_idx][1];
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    bht_d = bht_q;
    if (legal_resolve) begin
      if (taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end

    branch_count_d = branch_count_q;
    if (legal_resolve && (branch_count_q != {CNT_W{1'b1}}))
      branch_count_d = branch_count_q + 1'b1;

    mispredict_count_d = mispredict_count_q;
    if (mispred && (mispredict_count_q != {CNT_W{1'b1}}))
      mispredict_count_d = mispredict_count_q + 1'b1;
  end

  // Reset has priority, so an update presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= C_BHT_RST;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // PC bits outside the index field do not affect the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0],
                            bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

endmodule
`default_nettype wire

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
Next-generation branch unit for the pipelined RV32 core. It resolves conditional branches directly from EX-stage operands (XLEN-wide signed/unsigned compare, full RISC-V funct3 set) and compares the outcome against a prediction. It owns a PC-indexed branch history table (BHT) of 2-bit saturating counters that supplies taken/not-taken predictions to IF. It also keeps saturating performance counters for resolved branches and mispredicts.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_pc  in  XLEN  fetch PC to predict
pred_taken  out  1  prediction for if_pc; combinational read of the BHT
ex_valid  in  1  EX stage holds a valid instruction; low means stall or bubble
ex_is_branch  in  1  EX instruction is a conditional branch
ex_funct3  in  3  branch funct3
ex_pc  in  XLEN  PC of the EX branch
ex_rs1  in  XLEN  operand 1
ex_rs2  in  XLEN  operand 2
ex_pred_taken  in  1  prediction carried down the pipe with this branch
branch_taken  out  1  resolved outcome; combinational
mispredict  out  1  resolved outcome differs from ex_pred_taken; combinational
illegal_funct3  out  1  funct3 is 010 or 011 on a resolving branch
branch_count  out  CNT_W  resolved legal branches; saturating
mispredict_count  out  CNT_W  mispredicts; saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: every BHT entry is set to 2'b01 (weakly not-taken). branch_count and mispredict_count are set to 0. pred_taken therefore reads 0 for every PC in the cycle after reset.
- Reset mid-operation: reset clears everything in one cycle. Any update presented in the reset cycle is discarded.
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]. PC bits [1:0] are ignored.
- Prediction: pred_taken = BHT[idx(if_pc)][1]. Zero latency; no register.
- resolve = ex_valid & ex_is_branch.
- branch_taken, evaluated only when resolve = 1:
  - 000 BEQ: rs1 == rs2
  - 001 BNE: rs1 != rs2
  - 100 BLT: signed rs1 < rs2
  - 101 BGE: signed rs1 >= rs2
  - 110 BLTU: unsigned rs1 < rs2
  - 111 BGEU: unsigned rs1 >= rs2
  - 010 or 011: branch_taken = 0 and illegal_funct3 = 1.
- When resolve = 0: branch_taken, mispredict and illegal_funct3 are all 0.
- mispredict = resolve & !illegal_funct3 & (branch_taken != ex_pred_taken).
- BHT update at the clock edge when resolve = 1 and the funct3 is legal, at idx(ex_pc):
  - taken: counter increments, saturating at 11
  - not taken: counter decrements, saturating at 00
  - Illegal funct3 and stalls (ex_valid = 0) never update.
- Read/write collision: when idx(if_pc) == idx(ex_pc) in an update cycle, pred_taken shows the pre-update value. There is no bypass. The new value is visible in the next cycle.
- Counters: branch_count increments on each legal resolve. mispredict_count increments on each mispredict. Both hold at 2^CNT_W-1 and do not wrap.
- Arithmetic: compares are full XLEN. Signed compares treat bit XLEN-1 as sign. There are no flag inputs.

Test Plan:
- Reset, then sweep if_pc over 0x0 to 0xFC → pred_taken = 0 at every index. Both counters read 0.
- BEQ at ex_pc = 0x40 with rs1 = rs2 = 5 and ex_pred_taken = 0 → branch_taken = 1 and mispredict = 1. Next cycle pred_taken(0x40) = 1 and mispredict_count = 1. Repeat 3 times: entry saturates at 11. One not-taken outcome then brings it to 10, and pred_taken stays 1.
- rs1 = 0xFFFFFFFF, rs2 = 0x00000001:
  - funct3 100 → taken
  - funct3 110 → not taken
  - funct3 101 → not taken
  - funct3 111 → taken
  - funct3 001 → taken
- Aliasing and collision: update at ex_pc = 0x40 while if_pc = 0x140 (same index for 64 entries) → pred_taken shows the old value that cycle and the new value the following cycle.
- funct3 = 011 with resolve = 1 → illegal_funct3 = 1, branch_taken = 0, mispredict = 0, no BHT or counter change. ex_valid = 0 with ex_is_branch = 1 → no change at all.
- With CNT_W = 4, issue 20 mispredicting branches → both counters hold at 15. Assert rst_n = 0 mid-stream with an update pending → the update is discarded and all state is at reset values on the next cycle.
